// File: rtl/serial_fas_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// The overflow helper is only called when SERIAL_FAS_OVF_EN is defined.
package serial_fas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fas_state_e;

    localparam logic FAS_ADD = 1'b1;
    localparam logic FAS_SUB = 1'b0;

    // Signed overflow from the operand and result sign bits; a_ns picks add or subtract.
    function automatic logic fas_ovf(input logic a_ns, input logic a_msb,
                                     input logic b_msb, input logic s_msb);
        logic ovf_s;
        if (a_ns == FAS_ADD) begin
            ovf_s = (a_msb == b_msb) && (s_msb != a_msb);
        end else begin
            ovf_s = (a_msb != b_msb) && (s_msb != a_msb);
        end
        return ovf_s;
    endfunction

endpackage

// File: rtl/serial_fas_if.sv
// Operand and result handshake bundle for serial_fas.
interface serial_fas_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         a_ns;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, a_ns, cin, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, a_ns, cin, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/serial_fas_bit.sv
// One-bit full adder/subtractor cell: a_ns=1 adds with carry, a_ns=0 subtracts with borrow.
module fas_bit
    import serial_fas_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic a_ns,
    output logic s,
    output logic c_next
);

    // Sum bit is shared; only the carry/borrow term depends on the operation.
    always_comb begin
        s      = a ^ b ^ c;
        c_next = 1'b0;
        if (a_ns == FAS_ADD) begin
            c_next = (a & b) | (c & (a ^ b));
        end else begin
            c_next = (~a & b) | (c & ~(a ^ b));
        end
    end

endmodule

// File: rtl/serial_fas.sv
// Bit-serial add/subtract over W-bit operands, LSB first, one fas_bit step per clock.
// Define SERIAL_FAS_OVF_EN to register signed overflow; otherwise ovf is tied low.
module serial_fas
    import serial_fas_pkg::*;
#(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_fas_if.slave   bus
);

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    fas_state_e    state_r;
    fas_state_e    state_next_s;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  s_r;
    logic          a_ns_r;
    logic          carry_r;
    logic          cout_r;
    logic          sum_s;
    logic          carry_next_s;
    logic          last_bit_s;

    assign last_bit_s = (cnt_r == CNT_LAST);

    fas_bit u_fas_bit (
        .a      (a_r[cnt_r]),
        .b      (b_r[cnt_r]),
        .c      (carry_r),
        .a_ns   (a_ns_r),
        .s      (sum_s),
        .c_next (carry_next_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; accept and handoff never share an edge.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operand capture, bit stepping, result shift-in and final carry capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= {CW{1'b0}};
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            s_r     <= {W{1'b0}};
            a_ns_r  <= 1'b0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        a_ns_r  <= bus.a_ns;
                        carry_r <= bus.cin;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    // Each new bit enters at the MSB so bit 0 lands at s[0] after W steps.
                    s_r     <= {sum_s, s_r[W-1:1]};
                    carry_r <= carry_next_s;
                    if (last_bit_s) begin
                        cnt_r  <= {CW{1'b0}};
                        cout_r <= carry_next_s;
                    end else begin
                        cnt_r  <= cnt_r + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_FAS_OVF_EN
    logic ovf_r;

    // Overflow uses the live sum bit, which is the result MSB on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if ((state_r == ST_RUN) && last_bit_s) begin
            ovf_r <= fas_ovf(a_ns_r, a_r[W-1], b_r[W-1], sum_s);
        end
    end

    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = (state_r == ST_DONE);
    assign bus.s         = s_r;
    assign bus.cout      = cout_r;

endmodule

// File: tb/tb_serial_fas.sv
// Self-checking bench for serial_fas: arithmetic reference model plus per-cycle comparison.
module tb_serial_fas;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_fas_if #(.W(W)) bus ();

    serial_fas #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    res_t exp_q[$];
    bit   mdl_busy = 1'b0;
    int   mdl_cnt = 0;
    int   acc_cnt = 0;
    int   last_acc_cyc = 0;
    int   last_hnd_cyc = 0;
    bit   b2b_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result from plain integer arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ans, input logic ci);
        res_t r;
        int   full;
        int   sres;
        if (ans) begin
            full   = int'(a) + int'(b) + int'(ci);
            sres   = int'($signed(a)) + int'($signed(b)) + int'(ci);
            r.cout = (full >= (1 << W));
        end else begin
            full   = int'(a) - int'(b) - int'(ci);
            sres   = int'($signed(a)) - int'($signed(b)) - int'(ci);
            r.cout = (full < 0);
        end
        r.s = W'(full);
`ifdef SERIAL_FAS_OVF_EN
        r.ovf = (sres < -(1 << (W - 1))) || (sres > (1 << (W - 1)) - 1);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    // Transaction-level model: an op occupies the block for W edges, then waits for handoff.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mdl_busy = 1'b0;
                mdl_cnt  = 0;
                exp_q.delete();
            end else begin
                cyc++;
                if (!mdl_busy) begin
                    if (bus.in_valid) begin
                        exp_q.push_back(model(bus.a, bus.b, bus.a_ns, bus.cin));
                        if (b2b_mode) chk("b2b_spacing", cyc - last_acc_cyc, W + 2);
                        mdl_busy     = 1'b1;
                        mdl_cnt      = 0;
                        last_acc_cyc = cyc;
                        acc_cnt++;
                    end
                end else if (mdl_cnt < W) begin
                    mdl_cnt++;
                end else if (bus.out_ready) begin
                    mdl_busy     = 1'b0;
                    last_hnd_cyc = cyc;
                    if (exp_q.size() > 0) exp_q.pop_front();
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready", bus.in_ready, !mdl_busy);
                chk("out_valid", bus.out_valid, mdl_busy && (mdl_cnt == W));
                if (mdl_busy && (mdl_cnt == W) && (exp_q.size() > 0)) begin
                    chk("s", bus.s, exp_q[0].s);
                    chk("cout", bus.cout, exp_q[0].cout);
                    chk("ovf", bus.ovf, exp_q[0].ovf);
                end
            end
        end
    end

    task automatic wait_accept(input int n, input string name);
        int t = 0;
        while ((acc_cnt == n) && (t < 100)) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (acc_cnt == n) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ans, input logic ci);
        int n;
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.a_ns     = ans;
        bus.cin      = ci;
        bus.in_valid = 1'b1;
        n            = acc_cnt;
        wait_accept(n, "op");
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int t = 0;
        @(negedge clk);
        while (!bus.out_valid && (t < 100)) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid) chk({name, "_result_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ans, input logic ci, input logic [W-1:0] es,
                            input logic ec, input logic eo_on);
        logic eo;
`ifdef SERIAL_FAS_OVF_EN
        eo = eo_on;
`else
        eo = 1'b0;
`endif
        op(a, b, ans, ci);
        wait_out(name);
        chk({name, "_latency"}, cyc - last_acc_cyc, W);
        chk({name, "_s"}, bus.s, es);
        chk({name, "_cout"}, bus.cout, ec);
        chk({name, "_ovf"}, bus.ovf, eo);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.a_ns      = 1'b1;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_s", bus.s, 8'h00);
        chk("rst_cout", bus.cout, 1'b0);
        chk("rst_ovf", bus.ovf, 1'b0);

        directed("add_3c_05", 8'h3C, 8'h05, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0);
        directed("add_ff_01", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("add_7f_00_c", 8'h7F, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1);
        directed("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
        directed("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1);

        // Backpressure with a new request pending throughout.
        @(negedge clk);
        bus.out_ready = 1'b0;
        op(8'h11, 8'h22, 1'b1, 1'b0);
        wait_out("bp");
        bus.a        = 8'h01;
        bus.b        = 8'h02;
        bus.a_ns     = 1'b1;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        n            = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_s_hold", bus.s, 8'h33);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_out_valid", bus.out_valid, 1'b1);
        end
        bus.out_ready = 1'b1;
        wait_accept(n, "bp2");
        bus.in_valid = 1'b0;
        chk("bp_accept_gap", last_acc_cyc - last_hnd_cyc, 1);
        wait_out("bp2");
        chk("bp2_s", bus.s, 8'h03);

        // Asynchronous reset in the middle of a run.
        op(8'hAA, 8'h55, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
        chk("mid_rst_s", bus.s, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        directed("after_rst_add", 8'h10, 8'h20, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0);

        // Back-to-back random operations with in_valid and out_ready held high.
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra           = W'($urandom_range(0, (1 << W) - 1));
            rb           = W'($urandom_range(0, (1 << W) - 1));
            bus.a        = ra;
            bus.b        = rb;
            bus.a_ns     = 1'($urandom_range(0, 1));
            bus.cin      = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            n            = acc_cnt;
            wait_accept(n, "b2b");
            b2b_mode = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (W + 4) @(negedge clk);
        b2b_mode = 1'b0;
        chk("drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_fas.md
# serial_fas

Bit-serial adder/subtractor that runs one `fas_bit` cell per clock over W-bit operands, LSB first.
- Operands are accepted through a valid/ready input handshake and results returned through a valid/ready output handshake.
- Carry (add) or borrow (subtract) is held in a flop between bit steps.
- Sits beside the parallel gate-level add/sub path as its area-minimal sequential counterpart, and uses the same `a_ns` convention: 1 = add, 0 = subtract.

## Interface
Parameters:
- `W`, default 8: operand/result width, ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operands presented.
- `in_ready` out 1: block can accept operands.
- `a` in W: operand a.
- `b` in W: operand b.
- `a_ns` in 1: 1 computes a+b+cin; 0 computes a-b-cin.
- `cin` in 1: initial carry (add) or borrow (subtract).
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `s` out W: sum/difference.
- `cout` out 1: final carry (add) or borrow (subtract; 1 when a < b+cin, unsigned).
- `ovf` out 1: signed overflow; driven only with `SERIAL_FAS_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- `in_ready` = (state==IDLE). `out_valid` = (state==DONE). Both are decoded from state.

IDLE:
- `in_valid`&&`in_ready` at an edge loads `a`, `b`, `a_ns` into shift/hold registers and loads `cin` into the carry flop.
- Bit counter is cleared to 0; state goes to RUN.
- `in_valid` is ignored in RUN and DONE.

RUN, each edge:
- `fas_bit` takes a[cnt], b[cnt], carry and produces s[cnt] and the next carry/borrow. s[cnt] shifts into the result register MSB-side.
- cnt increments modulo W.
- The edge processing bit W-1 moves to DONE and stores the final carry as `cout`.

fas_bit equations:
- s = a^b^c.
- Add next carry = ab | c(a^b).
- Subtract next borrow = ~a·b | c·~(a^b).

DONE:
- `s`, `cout`, `ovf` are held stable until `out_valid`&&`out_ready` at an edge, then state goes to IDLE.
- No accept occurs on the same edge as result handoff; no bypass.

Arithmetic:
- Results are modulo 2^W; there is no sign extension.
- Counter width is $clog2(W).

Reset:
- Asynchronous; takes effect immediately, including mid-RUN or in DONE. The in-flight operation is discarded.
- State IDLE, so `in_ready`=1 after release.
- `out_valid`=0, `s`=0, `cout`=0, `ovf`=0, carry=0, cnt=0.

## Timing
- Operand accept at edge E0; `out_valid` rises after edge E0+W, i.e. W-cycle latency.
- Minimum initiation interval is W+2 cycles with `out_ready` held high: accept, W run edges, handoff.
- `s`, `cout`, `ovf` are registered outputs, constant while `out_valid`=1.
- `s` and `cout` may change during RUN and are qualified only by `out_valid`.
- `out_ready` low holds DONE indefinitely; `in_ready` stays 0 throughout.

## Configuration
- `SERIAL_FAS_OVF_EN` defined: `ovf` is registered at the final RUN edge.
  - Add: ovf = (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]).
  - Subtract: ovf = (a[W-1]!=b[W-1]) && (s[W-1]!=a[W-1]).
  - The stored a_ns selects the formula.
- Undefined: the `ovf` port remains and is tied to 0. No extra flops are kept.

## Structure
- `serial_fas_pkg` holds the state enum typedef (IDLE/RUN/DONE) and the a_ns encoding constants (FAS_ADD=1, FAS_SUB=0).
- One sub-module `fas_bit` (combinational: a, b, c, a_ns → s, c_next) is instantiated once. The top holds the FSM, counter, shift registers and handshakes.

## Test plan
W=8 for all scenarios:
- Add 0x3C+0x05, cin=0 → after 8 cycles s=0x41, cout=0, ovf=0.
- Add 0xFF+0x01, cin=0 → s=0x00, cout=1, ovf=0. Add 0x7F+0x00, cin=1 → s=0x80, ovf=1 (macro on).
- Subtract 0x05-0x07, cin=0 → s=0xFE, cout=1 (borrow). Subtract 0x80-0x01 → s=0x7F, cout=0, ovf=1 (macro on); ovf=0 with macro off.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` with `in_valid`=1 and new operands → s stable, `in_ready`=0, new operands not taken until one cycle after handoff.
- Reset mid-operation: assert `rst` 4 cycles after accept → `out_valid`=0 and `in_ready`=1 immediately (async). The next add 0x10+0x20 yields s=0x30, cout=0.
- Back-to-back ops with `out_ready`=1 and `in_valid`=1 → accepts spaced exactly 10 cycles; each result matches a software model, covering random a, b, cin and a_ns.
